llr_magnitude_seq: RTL and testbench

//  - Registered LLR-to-magnitude converter for the soft-decision BCH (Chase) decoder front end.
//  - Takes one signed LLR sample per enabled cycle and outputs its absolute value as an unsigned reliability.
//  - The LLR sign is dropped here; hard decision and alpha handling live in the wrapper.
//  - One instance per parallel lane; the wrapper replicates it PARALLELISM times.

---
 rtl/llr_magnitude_seq.sv | 52 +++++
 tb/tb_llr_magnitude_seq.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/llr_magnitude_seq.sv
// Purpose : registered LLR-to-magnitude converter, one per decoder lane.
// Latency : 1 clock from an enabled sample to out_llr_mag.
// Backpres: none; accepts one sample per clock when in_ctr_en=1, otherwise holds.
//
// Ports:
//   clk          rising-edge clock
//   in_ctr_Srst  asynchronous active-low reset, clears out_llr_mag at once
//   in_ctr_en    load enable; 1 = capture mag(in_llr) on this edge
//   in_llr       signed LLR sample, two's complement, MSB = sign
//   out_llr_mag  registered unsigned magnitude, LLR_LEN-1 bits
module llr_magnitude_seq #(
    parameter  int LLR_LEN     = 4,
    localparam int LLR_MAG_LEN = LLR_LEN - 1
) (
    input  logic                   clk,
    input  logic                   in_ctr_Srst,
    input  logic                   in_ctr_en,
    input  logic [LLR_LEN-1:0]     in_llr,
    output logic [LLR_MAG_LEN-1:0] out_llr_mag
);

    logic [LLR_LEN-1:0]     llr_neg;
    logic                   llr_is_min;
    logic [LLR_MAG_LEN-1:0] mag_d;
    logic [LLR_MAG_LEN-1:0] mag_q;

    // Two's-complement negation at full input width.
    assign llr_neg    = (~in_llr) + {{(LLR_LEN-1){1'b0}}, 1'b1};
    // The most-negative code has no positive counterpart in LLR_MAG_LEN bits;
    // negating it would wrap to 0, so it is caught and saturated instead.
    assign llr_is_min = in_llr[LLR_LEN-1] && (in_llr[LLR_LEN-2:0] == '0);

    always_comb begin
        mag_d = in_llr[LLR_MAG_LEN-1:0];
        if (llr_is_min) begin
            mag_d = '1;
        end else if (in_llr[LLR_LEN-1]) begin
            mag_d = llr_neg[LLR_MAG_LEN-1:0];
        end
    end

    always_ff @(posedge clk or negedge in_ctr_Srst) begin
        if (!in_ctr_Srst) begin
            mag_q <= '0;
        end else if (in_ctr_en) begin
            mag_q <= mag_d;
        end
    end

    assign out_llr_mag = mag_q;

endmodule

// File: tb/tb_llr_magnitude_seq.sv
module tb_llr_magnitude_seq;

    logic       clk;
    logic       rst_n;
    logic       en;
    logic [3:0] llr4;
    logic [2:0] mag4;
    logic [5:0] llr6;
    logic [4:0] mag6;

    int n_tests;
    int n_fail;

    llr_magnitude_seq #(.LLR_LEN(4)) u_dut4 (
        .clk         (clk),
        .in_ctr_Srst (rst_n),
        .in_ctr_en   (en),
        .in_llr      (llr4),
        .out_llr_mag (mag4)
    );

    llr_magnitude_seq #(.LLR_LEN(6)) u_dut6 (
        .clk         (clk),
        .in_ctr_Srst (rst_n),
        .in_ctr_en   (en),
        .in_llr      (llr6),
        .out_llr_mag (mag6)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached (got timeout, want finish)");
        $fatal(1, "watchdog");
    end

    // Reference: absolute value clamped to the largest magnitude that fits.
    function automatic int ref_mag(input int v, input int len);
        int a;
        int mx;
        a  = (v < 0) ? -v : v;
        mx = (1 << (len - 1)) - 1;
        return (a > mx) ? mx : a;
    endfunction

    task automatic check(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, want %0d", name, act, exp);
        end
    endtask

    // Drive inputs (called just after a negedge), take the posedge,
    // and return at the following negedge for sampling.
    task automatic cycle(input logic e, input int l4, input int l6);
        en   = e;
        llr4 = 4'(l4);
        llr6 = 6'(l6);
        @(posedge clk);
        @(negedge clk);
    endtask

    typedef struct {
        string name;
        logic  en;
        int    llr;
        int    exp;
    } vec_t;

    vec_t vecs[$];

    initial begin
        int exp4;
        int exp6;
        n_tests = 0;
        n_fail  = 0;
        rst_n   = 1'b0;
        en      = 1'b0;
        llr4    = '0;
        llr6    = '0;

        // Reset state and reset dominance over enable.
        #1;
        check("reset_state", int'(mag4), 0);
        @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            cycle(1'b1, 5, 21);
            check("reset_hold4", int'(mag4), 0);
            check("reset_hold6", int'(mag6), 0);
        end
        rst_n = 1'b1;

        // Table: sweep, saturation, enable gating, back-to-back stream.
        for (int v = 0; v < 8; v++) vecs.push_back('{"sweep_pos", 1'b1, v, v});
        vecs.push_back('{"neg1",   1'b1, -1, 1});
        vecs.push_back('{"neg3",   1'b1, -3, 3});
        vecs.push_back('{"neg7",   1'b1, -7, 7});
        vecs.push_back('{"neg8_sat", 1'b1, -8, 7});
        vecs.push_back('{"gate_load", 1'b1, -5, 5});
        for (int i = 0; i < 4; i++) vecs.push_back('{"gate_hold", 1'b0, 2, 5});
        vecs.push_back('{"gate_reload", 1'b1, 2, 2});
        vecs.push_back('{"b2b_3",  1'b1, 3, 3});
        vecs.push_back('{"b2b_m2", 1'b1, -2, 2});
        vecs.push_back('{"b2b_m8", 1'b1, -8, 7});
        vecs.push_back('{"b2b_0",  1'b1, 0, 0});
        foreach (vecs[i]) begin
            cycle(vecs[i].en, vecs[i].llr, 0);
            check(vecs[i].name, int'(mag4), vecs[i].exp);
        end

        // Reset mid-stream: async clear before the next edge, then resume.
        cycle(1'b1, 6, 0);
        check("pre_rst_6", int'(mag4), 6);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_clear", int'(mag4), 0);
        @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            cycle(1'b1, 6, 0);
            check("rst_held", int'(mag4), 0);
        end
        rst_n = 1'b1;
        cycle(1'b1, -4, 0);
        check("post_rst_m4", int'(mag4), 4);

        // Wider instance corner cases.
        cycle(1'b1, 0, -32);
        check("w6_m32_sat", int'(mag6), 31);
        cycle(1'b1, 0, -17);
        check("w6_m17", int'(mag6), 17);
        cycle(1'b1, 0, 31);
        check("w6_p31", int'(mag6), 31);

        // Randomized run against the reference, including async reset pulses.
        exp4 = int'(mag4);
        exp6 = int'(mag6);
        for (int i = 0; i < 400; i++) begin
            int  r4;
            int  r6;
            logic e;
            bit  do_rst;
            r4     = int'($urandom_range(0, 15)) - 8;
            r6     = int'($urandom_range(0, 63)) - 32;
            e      = 1'($urandom_range(0, 1));
            do_rst = ($urandom_range(0, 19) == 0);
            if (do_rst) begin
                rst_n = 1'b0;
                exp4  = 0;
                exp6  = 0;
            end else begin
                rst_n = 1'b1;
                if (e) begin
                    exp4 = ref_mag(r4, 4);
                    exp6 = ref_mag(r6, 6);
                end
            end
            cycle(e, r4, r6);
            check("rand4", int'(mag4), exp4);
            check("rand6", int'(mag6), exp6);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
